// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 measurement path.
// The checksum is the 8-bit wrapped sum of the four data bytes.
package dht11_pkg;
  localparam int FRAME_W = 40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return sum == f[7:0];
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond strobe: one-cycle pulse every CLK_HZ/1000 cycles.
module ms_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  assign tick_d = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/dht11_meas_sched.sv
// DHT11 measurement scheduler: request coalescing, auto-trigger, inter-read gap,
// response timeout and checksum-verified retries feeding the display registers.
module dht11_meas_sched
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned MIN_GAP_MS     = 2000,
  parameter int unsigned AUTO_PERIOD_MS = 5000,
  parameter int unsigned TIMEOUT_MS     = 50,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               auto_en,
  output logic               dht_start,
  input  logic               dht_done,
  input  logic [FRAME_W-1:0] dht_frame,
  output logic [7:0]         hum_int,
  output logic [7:0]         tmp_int,
  output logic               data_valid,
  output logic               err,
  output logic               busy,
  output logic [2:0]         state
);
  // Gap and timeout are measured in cycles so the minimum holds exactly,
  // independent of where the free-running ms strobe happens to be.
  localparam int unsigned CYC_MS  = CLK_HZ / 1000;
  localparam int unsigned GAP_CYC = MIN_GAP_MS * CYC_MS;
  localparam int unsigned TO_CYC  = TIMEOUT_MS * CYC_MS;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int AW = $clog2(AUTO_PERIOD_MS + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD_MS);
  localparam logic [2:0]    MAX_R    = 3'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [TW-1:0]      to_q, to_d;
  logic [AW-1:0]      auto_q, auto_d;
  logic [2:0]         attempt_q, attempt_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         hum_q, hum_d, tmp_q, tmp_d;
  logic               valid_q, valid_d, err_q, err_d;
  logic               tick, auto_fire, fail;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  assign auto_fire = auto_en && (auto_q == AUTO_MAX) && (state_q == S_IDLE);
  assign gap_d  = (state_q == S_START) ? '0 : (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
  assign to_d   = (state_q == S_WAIT) ? to_q + 1'b1 : '0;
  assign auto_d = (state_q != S_IDLE) ? '0 :
                  (tick && auto_q != AUTO_MAX) ? auto_q + 1'b1 : auto_q;

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    frame_d   = frame_q;
    hum_d     = hum_q;
    tmp_d     = tmp_q;
    valid_d   = valid_q;
    err_d     = err_q;
    fail      = 1'b0;
    case (state_q)
      S_IDLE: if (pending_q || req || auto_fire) begin
        state_d   = S_GAP;
        attempt_d = '0;
      end
      S_GAP:   if (gap_q == GAP_MAX) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // a done coinciding with the timeout still counts as a response
        if (dht_done) begin
          frame_d = dht_frame;
          state_d = S_CHECK;
        end else if (to_q == TO_LAST) begin
          fail = 1'b1;
        end
      end
      S_CHECK: begin
        if (frame_ok(frame_q)) begin
          hum_d   = frame_q[39:32];
          tmp_d   = frame_q[31:24];
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      if (attempt_q < MAX_R) begin
        attempt_d = attempt_q + 3'd1;
        state_d   = S_GAP;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  // Requests arriving while busy fold into a single follow-up measurement.
  assign pending_d = (state_q == S_IDLE && state_d != S_IDLE) ? 1'b0
                   : (pending_q || req || auto_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      to_q      <= '0;
      auto_q    <= '0;
      attempt_q <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      hum_q     <= '0;
      tmp_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      auto_q    <= auto_d;
      attempt_q <= attempt_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      hum_q     <= hum_d;
      tmp_q     <= tmp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign dht_start  = (state_q == S_START);
  assign busy       = (state_q != S_IDLE);
  assign state      = state_q;
  assign hum_int    = hum_q;
  assign tmp_int    = tmp_q;
  assign data_valid = valid_q;
  assign err        = err_q;
endmodule

// File: tb/tb_dht11_meas_sched.sv
// Directed + randomized bench for dht11_meas_sched; 1 ms = 10 cycles here.
module tb_dht11_meas_sched;
  import dht11_pkg::*;

  localparam int GAP_CYC  = 40;
  localparam int TO_CYC   = 30;
  localparam int ATTEMPTS = 3;
  localparam logic [40:0] TO = {1'b1, 40'h0};

  logic        clk = 1'b0;
  logic        rst, req, auto_en, dht_start, dht_done;
  logic [39:0] dht_frame;
  logic [7:0]  hum_int, tmp_int;
  logic        data_valid, err, busy;
  logic [2:0]  state;

  int cyc = 0, n_start = 0, checks = 0, errors = 0;
  int prev_start = -1, first_start = -1, extra_req = 0;
  logic [7:0] exp_hum = '0, exp_tmp = '0;
  logic       exp_valid = 1'b0, exp_err = 1'b0;

  dht11_meas_sched #(
    .CLK_HZ(10_000), .MIN_GAP_MS(4), .AUTO_PERIOD_MS(5), .TIMEOUT_MS(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en), .dht_start(dht_start),
    .dht_done(dht_done), .dht_frame(dht_frame), .hum_int(hum_int), .tmp_int(tmp_int),
    .data_valid(data_valid), .err(err), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst === 1'b1 && dht_start === 1'b1) n_start <= n_start + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ok(input logic [39:0] f);
    int s;
    s = (f[39:32] + f[31:24] + f[23:16] + f[15:8]) % 256;
    return int'(f[7:0]) == s;
  endfunction

  function automatic logic [39:0] mkframe(input bit bad);
    logic [7:0] b4, b3, b2, b1;
    int s;
    b4 = 8'($urandom); b3 = 8'($urandom); b2 = 8'($urandom); b1 = 8'($urandom);
    s = (b4 + b3 + b2 + b1) % 256;
    if (bad) s = s ^ int'($urandom_range(1, 255));
    return {b4, b3, b2, b1, 8'(s)};
  endfunction

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dht_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic trigger();
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic do_attempt(input logic [40:0] r, output bit ok);
    bit seen;
    int w;
    ok = 1'b0;
    wait_start(200, seen);
    chk("start_seen", seen, 1);
    if (!seen) return;
    if (prev_start >= 0) chk("gap_spacing", (cyc - prev_start) >= GAP_CYC, 1);
    if (first_start < 0) first_start = cyc;
    prev_start = cyc;
    for (int i = 0; i < extra_req; i++) begin
      tick(1); req = 1'b1; tick(1); req = 1'b0;
    end
    if (r[40]) begin
      w = 0;
      tick(1);
      while (state === 3'd3 && w < 100) begin
        w++;
        tick(1);
      end
      chk("wait_len", w, TO_CYC);
    end else begin
      tick($urandom_range(1, 12));
      dht_done = 1'b1; dht_frame = r[39:0];
      tick(1);
      dht_done = 1'b0; dht_frame = {$urandom, 8'($urandom)};
      chk("hold_hum", hum_int, exp_hum);
      chk("hold_valid", data_valid, exp_valid);
      ok = model_ok(r[39:0]);
    end
  endtask

  task automatic measure(input logic [40:0] r0, input logic [40:0] r1,
                         input logic [40:0] r2, input bit idle_chk);
    logic [40:0] rs [ATTEMPTS];
    bit ok, good;
    int s0, att;
    rs[0] = r0; rs[1] = r1; rs[2] = r2;
    s0 = n_start; good = 1'b0; att = 0;
    for (int a = 0; a < ATTEMPTS && !good; a++) begin
      do_attempt(rs[a], ok);
      att++;
      if (ok) begin
        good = 1'b1;
        exp_hum = rs[a][39:32]; exp_tmp = rs[a][31:24];
        exp_valid = 1'b1; exp_err = 1'b0;
      end
    end
    if (!good) exp_err = 1'b1;
    tick(1);
    chk("hum_int", hum_int, exp_hum);
    chk("tmp_int", tmp_int, exp_tmp);
    chk("data_valid", data_valid, exp_valid);
    chk("err", err, exp_err);
    if (idle_chk) chk("busy_idle", busy, 0);
    chk("n_attempts", n_start - s0, att);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_hum"}, hum_int, 0);
    chk({tag, "_tmp"}, tmp_int, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_start"}, dht_start, 0);
  endtask

  initial begin
    logic [40:0] rr [3];
    bit seen;
    int rel, idle_at, s;

    rst = 1'b0; req = 1'b0; auto_en = 1'b0; dht_done = 1'b0; dht_frame = '0;
    tick(3);
    chk_cleared("reset");
    rst = 1'b1;
    rel = cyc;

    // power-up gap and a first good frame with its two-cycle latency
    tick(1);
    trigger();
    measure({1'b0, 40'h3700_1900_50}, TO, TO, 1'b1);
    chk("pwr_gap", (first_start - rel) >= GAP_CYC, 1);

    // checksum wrap accepted, then three bad checksums exhaust the retries
    trigger();
    measure({1'b0, 40'hFF01_0101_02}, TO, TO, 1'b1);
    trigger();
    measure({1'b0, 40'h3700_1900_51}, {1'b0, 40'h3700_1900_51}, {1'b0, 40'h3700_1900_51}, 1'b1);

    // no response at all
    trigger();
    measure(TO, TO, TO, 1'b1);

    // random mix of good, corrupted and missing frames
    for (int k = 0; k < 5; k++) begin
      for (int a = 0; a < 3; a++) begin
        case ($urandom_range(0, 3))
          0:       rr[a] = TO;
          1:       rr[a] = {1'b0, mkframe(1'b1)};
          default: rr[a] = {1'b0, mkframe(1'b0)};
        endcase
      end
      trigger();
      measure(rr[0], rr[1], rr[2], 1'b1);
    end

    // three requests while busy coalesce into one follow-up read
    trigger();
    extra_req = 3;
    measure({1'b0, mkframe(1'b0)}, TO, TO, 1'b0);
    extra_req = 0;
    measure({1'b0, mkframe(1'b0)}, TO, TO, 1'b1);
    s = n_start;
    tick(100);
    chk("no_extra_start", n_start - s, 0);

    // stray done in IDLE
    dht_done = 1'b1; dht_frame = 40'h1122_3344_AA;
    tick(1);
    dht_done = 1'b0;
    tick(3);
    chk("stray_hum", hum_int, exp_hum);
    chk("stray_tmp", tmp_int, exp_tmp);
    chk("stray_state", state, 0);
    chk("stray_no_start", n_start - s, 0);

    // auto-trigger period from IDLE entry, then async reset mid-WAIT
    auto_en = 1'b1;
    trigger();
    measure({1'b0, mkframe(1'b0)}, TO, TO, 1'b1);
    idle_at = cyc;
    wait_start(100, seen);
    chk("auto_start_seen", seen, 1);
    chk("auto_window", (cyc - idle_at) >= 40 && (cyc - idle_at) <= 55, 1);
    tick(5);
    chk("mid_wait", state, 3);
    #3 rst = 1'b0;
    #1;
    chk_cleared("async_rst");
    exp_hum = '0; exp_tmp = '0; exp_valid = 1'b0; exp_err = 1'b0;
    auto_en = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("post_rst_state", state, 0);
    chk("post_rst_valid", data_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dht11_meas_sched.md
Name: dht11_meas_sched

Overview:
Measurement scheduler that sequences the DHT11 sensor controller. It accepts debounced button requests and an optional periodic auto-trigger, and enforces the sensor's minimum inter-read gap. It issues start pulses to the DHT11 controller, applies a response timeout, verifies the 40-bit frame checksum with bounded retries, and latches validated humidity and temperature for the FND path.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; must be a multiple of 1000.
MIN_GAP_MS, 2000, minimum ms between consecutive dht_start pulses; also enforced after reset.
AUTO_PERIOD_MS, 5000, ms from the end of one measurement to the next auto-trigger.
TIMEOUT_MS, 50, ms to wait for dht_done before declaring the attempt failed.
MAX_RETRY, 3, extra attempts after a failed first attempt (1..7).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  1  one-cycle measurement request (debounced button)
auto_en  in  1  level; enables periodic auto-trigger
dht_start  out  1  one-cycle start pulse to the DHT11 controller
dht_done  in  1  one-cycle pulse; the frame on dht_frame is valid this cycle
dht_frame  in  40  {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first
hum_int  out  8  last validated humidity integer byte
tmp_int  out  8  last validated temperature integer byte
data_valid  out  1  set on the first good frame; never cleared except by reset
err  out  1  set when all attempts fail; cleared on the next good frame
busy  out  1  high in every state except IDLE
state  out  3  encoded FSM state for LEDs/debug

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, gap_ms=0, auto_ms=0, attempt=0, pending=0.
- ms tick: one-cycle pulse every CLK_HZ/1000 cycles.
- gap_ms: counts ms ticks and saturates at MIN_GAP_MS. Cleared in the START cycle. Reset to 0 covers sensor power-up settling.
- auto_ms: counts ms ticks while in IDLE and saturates at AUTO_PERIOD_MS. Cleared on every return to IDLE.
- pending: set by req in any state, or by auto_en=1 with auto_ms==AUTO_PERIOD_MS in IDLE. Cleared on leaving IDLE. Multiple requests coalesce into one measurement.
- FSM encoding: IDLE=0, GAP=1, START=2, WAIT=3, CHECK=4.
  - IDLE: if pending (or req this cycle) -> GAP; attempt <= 0.
  - GAP: when gap_ms==MIN_GAP_MS -> START. If the gap is already satisfied, GAP lasts exactly 1 cycle.
  - START: dht_start=1 for exactly this cycle; clear gap_ms and timeout counter -> WAIT.
  - WAIT: dht_done=1 -> capture dht_frame into frame_r -> CHECK. Timeout counter reaching TIMEOUT_MS -> fail path. If dht_done and timeout coincide, dht_done wins.
  - CHECK (1 cycle): good when frame_r[7:0] == (b4+b3+b2+b1) mod 256 (8-bit wrap).
    - Good: hum_int<=b4, tmp_int<=b3, data_valid<=1, err<=0 -> IDLE.
    - Bad: fail path.
  - Fail path (bad checksum or timeout): if attempt < MAX_RETRY, attempt++ -> GAP (retry honours MIN_GAP_MS). Otherwise err<=1, outputs hold previous values -> IDLE.
- dht_done outside WAIT is ignored.
- Outputs hum_int/tmp_int/data_valid/err update the cycle after CHECK (registered). The error path updates the cycle after WAIT/CHECK.
- Latency with gap satisfied, req at cycle 0: GAP at 1, dht_start at 2, WAIT from 3. A done at cycle N gives updated outputs at N+2.

Decomposition:
- dht11_pkg: state enum/localparams (IDLE..CHECK), FRAME_W=40, and a checksum function over a 40-bit frame.
- One sub-module, ms_tick_gen (parameter CLK_HZ; clk, rst, tick out), reusable by the FND and debounce blocks.

Test Plan:
(Bench uses CLK_HZ=10_000, i.e. 1 ms = 10 cycles; MIN_GAP_MS=4, TIMEOUT_MS=3, MAX_RETRY=2.)
1. Power-up: req 1 cycle after reset release -> dht_start asserted exactly once, no earlier than 40 cycles after release.
2. Good frame: 40'h3700_1900_50 on dht_done -> hum_int=0x37, tmp_int=0x19, data_valid=1, err=0 two cycles later.
3. Checksum wrap: 40'hFF01_0101_02 (sum 0x102 -> 0x02) -> accepted. 40'h3700_1900_51 three times -> exactly 3 dht_start pulses, consecutive pulses at least 40 cycles apart, then err=1 with hum_int/tmp_int unchanged.
4. Timeout: never assert dht_done -> each WAIT lasts 30 cycles, 3 attempts total, then err=1 and busy=0.
5. Coalescing: 3 req pulses while busy -> exactly one further measurement after return to IDLE. A stray dht_done in IDLE -> no output change.
6. Auto mode with AUTO_PERIOD_MS=5, auto_en=1: after a good read, the next dht_start occurs 50 cycles after IDLE entry (gap already met). Async reset mid-WAIT clears all outputs immediately.
